mult_eval_sched: RTL and testbench
==================================

MULT_EVAL_SCHED -- requirements
Module: mult_eval_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 2, setting the operand width of the candidate multiplier under evaluation.
REQ-002 SHALL have parameter LAT, default 0, range 0..3, giving the number of register stages between dut_a/dut_b and dut_p.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin an exhaustive sweep.
REQ-006 SHALL have port abort  input  1  cancels a sweep in progress.
REQ-007 SHALL have port dut_a  output  WIDTH  registered operand A driven to the candidate.
REQ-008 SHALL have port dut_b  output  WIDTH  registered operand B driven to the candidate.
REQ-009 SHALL have port dut_p  input  2*WIDTH  product returned by the candidate.
REQ-010 SHALL have port busy  output  1  high in SWEEP and DRAIN.
REQ-011 SHALL have port done  output  1  one-cycle pulse when results become valid.
REQ-012 SHALL have port err_count  output  2*WIDTH+1  number of mismatching vectors.
REQ-013 SHALL have port pass  output  1  high when the last completed sweep had err_count==0.
REQ-014 SHALL have port ff_valid, ff_a, ff_b  outputs  1, WIDTH, WIDTH  first failing vector.

Function
REQ-015 SHALL implement FSM states IDLE, SWEEP, DRAIN, DONE.
REQ-016 IDLE->SWEEP on start; clears err_count, pass, ff_valid and the vector index k to 0.
REQ-017 In SWEEP, vector k SHALL drive dut_a=k[2W-1:W] and dut_b=k[W-1:0], with k incrementing by one per cycle from 0 to 2^(2W)-1.
REQ-018 Expected product A*B SHALL be computed at full 2*WIDTH width with no truncation.
REQ-019 Expected products SHALL be delayed LAT cycles, so vector k is compared with dut_p at the edge ending cycle k+LAT.
REQ-020 SWEEP->DRAIN after the last vector is driven; DRAIN SHALL last exactly LAT cycles, or 0 cycles when LAT=0.
REQ-021 DONE SHALL last one cycle, assert done, then return to IDLE.
REQ-022 Cycles from the start-accept edge to the done cycle SHALL equal 2^(2W)+LAT+1.
REQ-023 On each mismatch, err_count SHALL increment, saturating at 2^(2W).
REQ-024 On the first mismatch only, ff_a/ff_b SHALL be captured and ff_valid set.
REQ-025 start SHALL be ignored while busy.
REQ-026 abort in SWEEP or DRAIN SHALL force IDLE next cycle, with no done pulse and err_count, pass and ff_valid cleared.
REQ-027 If abort and start are high together in IDLE, start SHALL win.
REQ-028 Results SHALL be held stable from done until the next accepted start.

Reset
REQ-029 On rst, state SHALL be IDLE and dut_a, dut_b, busy, done, err_count, pass, ff_valid, ff_a, ff_b, k and the delay line SHALL all be 0, asynchronously.
REQ-030 rst asserted mid-sweep SHALL discard all results, with no done pulse.

Configuration
REQ-031 With macro MULT_EVAL_ERRSUM_EN defined, the block SHALL add output err_sum (4*WIDTH bits) that accumulates |dut_p - A*B| over all compared vectors, cleared by start/abort/rst and saturating at all-ones.
REQ-032 Without MULT_EVAL_ERRSUM_EN, the err_sum port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-033 The state enum, the LAT maximum (3) and vector-count/width helper constants SHALL reside in shared package mult_eval_pkg.
REQ-034 The expected-product delay line SHALL be a sub-module mult_eval_delay (parameters WIDTH, LAT).
REQ-035 The candidate multiplier SHALL remain external; the block only drives and samples it.

Verification
REQ-036 WIDTH=2, LAT=0, exact multiplier -> done at cycle 17 after start, err_count=0, pass=1, ff_valid=0.
REQ-037 WIDTH=2, LAT=0, candidate P=0 -> err_count=9, pass=0, ff_a=1, ff_b=1; with MULT_EVAL_ERRSUM_EN, err_sum=36.
REQ-038 WIDTH=2, LAT=2, exact 2-stage registered multiplier -> done at cycle 19, err_count=0; same candidate with LAT=0 -> err_count>0.
REQ-039 start pulsed again at cycle 5 of a sweep -> ignored, single done pulse at cycle 17, results identical to REQ-036.
REQ-040 abort at cycle 6 -> busy low at cycle 7, no done pulse, err_count=0; a following start runs a complete normal sweep.
REQ-041 rst asserted at cycle 8 of a faulty-candidate sweep -> all outputs 0 immediately, state IDLE, no done pulse.

Source files
------------

// File: rtl/mult_eval_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | mult_eval_pkg: shared types and sizing helpers for mult_eval_sched  |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
package mult_eval_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int LAT_MAX = 3;

  // Vector index width and vector count for a WIDTH x WIDTH operand space.
  function automatic int vec_bits(input int width);
    return 2 * width;
  endfunction

  function automatic int num_vectors(input int width);
    return 1 << (2 * width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_eval_sched_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | mult_eval_sched_if: control/result and candidate bus of the sweeper |
// | err_sum exists only with MULT_EVAL_ERRSUM_EN.  Rev 1.0              |
// +---------------------------------------------------------------------+
interface mult_eval_sched_if #(
  parameter int WIDTH = 2
);
  logic                 start;
  logic                 abort;
  logic [WIDTH-1:0]     dut_a;
  logic [WIDTH-1:0]     dut_b;
  logic [2*WIDTH-1:0]   dut_p;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH:0]     err_count;
  logic                 pass;
  logic                 ff_valid;
  logic [WIDTH-1:0]     ff_a;
  logic [WIDTH-1:0]     ff_b;
`ifdef MULT_EVAL_ERRSUM_EN
  logic [4*WIDTH-1:0]   err_sum;
`endif

  modport master (
    input  start, abort, dut_p,
    output dut_a, dut_b, busy, done, err_count, pass, ff_valid, ff_a, ff_b
`ifdef MULT_EVAL_ERRSUM_EN
    , output err_sum
`endif
  );

  modport slave (
    output start, abort, dut_p,
    input  dut_a, dut_b, busy, done, err_count, pass, ff_valid, ff_a, ff_b
`ifdef MULT_EVAL_ERRSUM_EN
    , input err_sum
`endif
  );
endinterface
`default_nettype wire

// File: rtl/mult_eval_delay.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | mult_eval_delay: LAT-stage line carrying {valid, A, B, A*B}         |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module mult_eval_delay #(
  parameter int WIDTH = 2,
  parameter int LAT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_a,
  output logic [WIDTH-1:0]     out_b,
  output logic [2*WIDTH-1:0]   out_exp
);
  localparam int PW = 2 * WIDTH;
  localparam int DW = 1 + 2 * WIDTH + PW;

  logic [PW-1:0] prod;
  logic [DW-1:0] head;
  logic [DW-1:0] tail;

  // Operands are widened first so the product is never truncated.
  assign prod = PW'(in_a) * PW'(in_b);
  assign head = {in_valid, in_a, in_b, prod};

  generate
    if (LAT == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = ^{clk, rst, clr};
      assign tail = head;
    end else begin : g_pipe
      logic [DW-1:0] stage [LAT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
          stage[0] <= head;
          for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
      end
      assign tail = stage[LAT-1];
    end
  endgenerate

  assign {out_valid, out_a, out_b, out_exp} = tail;

endmodule
`default_nettype wire

// File: rtl/mult_eval_sched.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | mult_eval_sched: exhaustive A*B sweep of an external multiplier     |
// | Optional err_sum output with MULT_EVAL_ERRSUM_EN.  Rev 1.0          |
// +---------------------------------------------------------------------+
module mult_eval_sched
  import mult_eval_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int LAT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  mult_eval_sched_if.master bus
);
  localparam int VW = vec_bits(WIDTH);
  localparam int CW = VW + 1;
  localparam int DW = $clog2(LAT_MAX + 1);
  localparam logic [VW-1:0] K_LAST     = '1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(num_vectors(WIDTH));
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);

  state_t          state, state_nx;
  logic [VW-1:0]   k;
  logic [DW-1:0]   drain_cnt;
  logic [CW-1:0]   err_count, err_nx;
  logic            pass, ff_valid;
  logic [WIDTH-1:0] ff_a, ff_b;
  logic            busy, done, sweeping, last_vec, accept, kill, cmp_en, mismatch;
  logic            d_valid;
  logic [WIDTH-1:0] d_a, d_b;
  logic [VW-1:0]   d_exp;

  assign sweeping = (state == ST_SWEEP);
  assign last_vec = (k == K_LAST);
  assign accept   = (state == ST_IDLE) && bus.start;
  assign kill     = busy && bus.abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nx = ST_SWEEP;
      ST_SWEEP: begin
        if (bus.abort)    state_nx = ST_IDLE;
        else if (last_vec) state_nx = (LAT == 0) ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.abort)                   state_nx = ST_IDLE;
        else if (drain_cnt == DRAIN_LAST) state_nx = ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_SWEEP, ST_DRAIN: busy = 1'b1;
      ST_DONE:            done = 1'b1;
      default:            ;
    endcase
  end

  mult_eval_delay #(.WIDTH(WIDTH), .LAT(LAT)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept | kill),
    .in_valid (sweeping),
    .in_a     (k[VW-1:WIDTH]),
    .in_b     (k[WIDTH-1:0]),
    .out_valid(d_valid),
    .out_a    (d_a),
    .out_b    (d_b),
    .out_exp  (d_exp)
  );

  assign cmp_en   = busy && d_valid;
  assign mismatch = cmp_en && (bus.dut_p != d_exp);

  always_comb begin
    err_nx = err_count;
    if (mismatch && (err_count != CNT_MAX)) err_nx = err_count + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k         <= '0;
      drain_cnt <= '0;
      err_count <= '0;
      pass      <= 1'b0;
      ff_valid  <= 1'b0;
      ff_a      <= '0;
      ff_b      <= '0;
    end else if (accept || kill) begin
      k         <= '0;
      drain_cnt <= '0;
      err_count <= '0;
      pass      <= 1'b0;
      ff_valid  <= 1'b0;
    end else begin
      if (sweeping && !last_vec) k <= k + VW'(1);
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DW'(1) : '0;
      err_count <= err_nx;
      if (mismatch && !ff_valid) begin
        ff_valid <= 1'b1;
        ff_a     <= d_a;
        ff_b     <= d_b;
      end
      // The final comparison lands on the same edge that enters DONE.
      if (state_nx == ST_DONE) pass <= (err_nx == '0);
    end
  end

`ifdef MULT_EVAL_ERRSUM_EN
  localparam int SW = 4 * WIDTH;
  logic [SW-1:0] err_sum;
  logic [VW-1:0] abs_diff;
  logic [SW:0]   sum_wide;

  assign abs_diff = (bus.dut_p >= d_exp) ? (bus.dut_p - d_exp) : (d_exp - bus.dut_p);
  assign sum_wide = {1'b0, err_sum} + {{(SW + 1 - VW){1'b0}}, abs_diff};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 err_sum <= '0;
    else if (accept || kill) err_sum <= '0;
    else if (cmp_en)         err_sum <= sum_wide[SW] ? '1 : sum_wide[SW-1:0];
  end

  assign bus.err_sum = err_sum;
`endif

  assign bus.dut_a     = k[VW-1:WIDTH];
  assign bus.dut_b     = k[WIDTH-1:0];
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err_count = err_count;
  assign bus.pass      = pass;
  assign bus.ff_valid  = ff_valid;
  assign bus.ff_a      = ff_a;
  assign bus.ff_b      = ff_b;

endmodule
`default_nettype wire

// File: tb/tb_mult_eval_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------+
// | tb_mult_eval_sched: randomized bench for LAT=0 and LAT=2 sweepers   |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module tb_mult_eval_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_eval_sched_if #(.WIDTH(2)) bus0();
  mult_eval_sched_if #(.WIDTH(2)) bus2();

  mult_eval_sched #(.WIDTH(2), .LAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mult_eval_sched #(.WIDTH(2), .LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_checks = 0;
  int n_errors = 0;

  // Candidate modes: 0 exact, 1 constant zero, 2 exact xor fault_mask, 3 two-stage registered
  logic [3:0] fault_mask [16];
  int mode0 = 0;
  int mode2 = 0;
  logic [3:0] p0_s1, p0_s2, p2_s1, p2_s2;

  function automatic logic [3:0] cand(input int mode, input logic [1:0] a, input logic [1:0] b);
    logic [3:0] ab;
    ab = {2'b00, a} * {2'b00, b};
    if (mode == 1) return 4'd0;
    if (mode == 2) return ab ^ fault_mask[{a, b}];
    return ab;
  endfunction

  always @(posedge clk) begin
    p0_s1 <= cand(0, bus0.dut_a, bus0.dut_b);
    p0_s2 <= p0_s1;
    p2_s1 <= cand(mode2, bus2.dut_a, bus2.dut_b);
    p2_s2 <= p2_s1;
  end

  always_comb begin
    bus0.dut_p = cand(mode0, bus0.dut_a, bus0.dut_b);
    if (mode0 == 3) bus0.dut_p = p0_s2;
  end
  assign bus2.dut_p = p2_s2;

  logic       sel;
  logic       obs_busy, obs_done, obs_pass, obs_ffv;
  logic [4:0] obs_err;
  logic [1:0] obs_ffa, obs_ffb;
  assign obs_busy = sel ? bus2.busy      : bus0.busy;
  assign obs_done = sel ? bus2.done      : bus0.done;
  assign obs_pass = sel ? bus2.pass      : bus0.pass;
  assign obs_ffv  = sel ? bus2.ff_valid  : bus0.ff_valid;
  assign obs_err  = sel ? bus2.err_count : bus0.err_count;
  assign obs_ffa  = sel ? bus2.ff_a      : bus0.ff_a;
  assign obs_ffb  = sel ? bus2.ff_b      : bus0.ff_b;
`ifdef MULT_EVAL_ERRSUM_EN
  logic [7:0] obs_sum;
  assign obs_sum = sel ? bus2.err_sum : bus0.err_sum;
`endif

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_start(input int which, input logic v);
    if (which == 2) bus2.start = v; else bus0.start = v;
  endtask

  task automatic drive_abort(input int which, input logic v);
    if (which == 2) bus2.abort = v; else bus0.abort = v;
  endtask

  // Reference: walk all 16 operand pairs and score the candidate's answer.
  task automatic model(input int mode, output int ec, output int fv, output int fa,
                       output int fb, output int es);
    int a, b, prod, p;
    ec = 0; fv = 0; fa = 0; fb = 0; es = 0;
    for (int v = 0; v < 16; v++) begin
      a = v / 4;
      b = v % 4;
      prod = a * b;
      if (mode == 1)      p = 0;
      else if (mode == 2) p = prod ^ int'(fault_mask[v]);
      else                p = prod;
      if (p != prod) begin
        if (fv == 0) begin fv = 1; fa = a; fb = b; end
        ec++;
        es += (p > prod) ? (p - prod) : (prod - p);
      end
    end
    if (ec > 16) ec = 16;
    if (es > 255) es = 255;
  endtask

  // Cycle 1 is the cycle right after the edge that accepts start.
  task automatic run(input int which, input int again_at, input int abort_at,
                     output int done_cyc, output int done_cnt, output int busy_mark,
                     output int err_at_done);
    sel = (which == 2);
    drive_start(which, 1'b1);
    @(posedge clk); #1;
    drive_start(which, 1'b0);
    done_cyc = 0; done_cnt = 0; busy_mark = -1; err_at_done = -1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (obs_done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) begin done_cyc = cyc; err_at_done = int'(obs_err); end
      end
      if (abort_at > 0 && cyc == abort_at + 1) busy_mark = int'(obs_busy);
      if (cyc == again_at) drive_start(which, 1'b1);
      if (cyc == abort_at) drive_abort(which, 1'b1);
      @(posedge clk); #1;
      drive_start(which, 1'b0);
      drive_abort(which, 1'b0);
    end
  endtask

  task automatic verify(input string tag, input int mode, input int lat, input int dc,
                        input int dcnt, input int errdone);
    int ec, fv, fa, fb, es;
    model(mode, ec, fv, fa, fb, es);
    check_val({tag, "_done_cycle"}, dc, 17 + lat);
    check_val({tag, "_done_count"}, dcnt, 1);
    check_val({tag, "_err_count"}, obs_err, ec);
    check_val({tag, "_err_held"}, errdone, ec);
    check_val({tag, "_pass"}, obs_pass, (ec == 0));
    check_val({tag, "_ff_valid"}, obs_ffv, fv);
    if (fv != 0) begin
      check_val({tag, "_ff_a"}, obs_ffa, fa);
      check_val({tag, "_ff_b"}, obs_ffb, fb);
    end
`ifdef MULT_EVAL_ERRSUM_EN
    check_val({tag, "_err_sum"}, obs_sum, es);
`endif
  endtask

  initial begin
    int dc, dcnt, bm, ed, which;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus2.start = 1'b0; bus2.abort = 1'b0;
    sel = 1'b0;
    for (int i = 0; i < 16; i++) fault_mask[i] = 4'd0;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy0", bus0.busy, 0);
    check_val("rst_done0", bus0.done, 0);
    check_val("rst_err0", bus0.err_count, 0);
    check_val("rst_pass0", bus0.pass, 0);
    check_val("rst_dut_ab0", {bus0.dut_a, bus0.dut_b}, 0);
    check_val("rst_busy2", bus2.busy, 0);
    check_val("rst_ffv2", bus2.ff_valid, 0);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    mode0 = 0;
    run(0, 0, 0, dc, dcnt, bm, ed);
    verify("exact_l0", 0, 0, dc, dcnt, ed);

    mode0 = 1;
    run(0, 0, 0, dc, dcnt, bm, ed);
    verify("zero_l0", 1, 0, dc, dcnt, ed);
    check_val("zero_l0_nine", obs_err, 9);

    mode2 = 0;
    run(2, 0, 0, dc, dcnt, bm, ed);
    verify("exact_l2", 0, 2, dc, dcnt, ed);

    mode0 = 3;
    run(0, 0, 0, dc, dcnt, bm, ed);
    check_val("reg_cand_l0_errs", (obs_err > 0), 1);

    mode0 = 0;
    run(0, 5, 0, dc, dcnt, bm, ed);
    verify("restart_ignored", 0, 0, dc, dcnt, ed);

    mode0 = 1;
    run(0, 0, 6, dc, dcnt, bm, ed);
    check_val("abort_busy", bm, 0);
    check_val("abort_no_done", dcnt, 0);
    check_val("abort_err", obs_err, 0);
    check_val("abort_pass", obs_pass, 0);
    check_val("abort_ffv", obs_ffv, 0);
    mode0 = 0;
    run(0, 0, 0, dc, dcnt, bm, ed);
    verify("after_abort", 0, 0, dc, dcnt, ed);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) begin
        if (it == 5 || $urandom_range(0, 1) == 1) fault_mask[i] = 4'($urandom_range(1, 15));
        else                                      fault_mask[i] = 4'd0;
      end
      which = ($urandom_range(0, 1) == 1) ? 2 : 0;
      mode0 = 2;
      mode2 = 2;
      run(which, 0, 0, dc, dcnt, bm, ed);
      verify($sformatf("rand%0d_l%0d", it, which), 2, which, dc, dcnt, ed);
    end

    mode0 = 1;
    sel = 1'b0;
    drive_start(0, 1'b1);
    @(posedge clk); #1;
    drive_start(0, 1'b0);
    repeat (7) begin @(posedge clk); #1; end
    check_val("pre_rst_err", (obs_err > 0), 1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_busy", bus0.busy, 0);
    check_val("mid_rst_err", bus0.err_count, 0);
    check_val("mid_rst_dut_ab", {bus0.dut_a, bus0.dut_b}, 0);
    check_val("mid_rst_ff", {bus0.ff_valid, bus0.ff_a, bus0.ff_b}, 0);
    check_val("mid_rst_pass_done", {bus0.pass, bus0.done}, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus0.done === 1'b1) dcnt++;
    end
    check_val("post_rst_no_done", dcnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
